// File: rtl/note_seq_ctrl.sv
// -----------------------------------------------------------------------------
// note_seq_ctrl -- melody sequencer feeding the note generator.
//
// The keyboard/recorder logic appends notes to a small memory while the
// sequencer is stopped. On play the sequencer steps through the notes at a
// tempo chosen by speed_i. A silent gap of GAP_CYC cycles separates notes, and
// the sequence can loop. Silence is sent to the note generator as note_div = 1.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   wr_en_i         append {wr_note_i, wr_len_i} (IDLE and not full only)
//   wr_note_i[5:0]  0 = rest, 1..48 = C3..B6, 49..63 treated as rest
//   wr_len_i[2:0]   duration in beats minus one
//   clr_i           empty the memory (IDLE only; wins over wr_en_i)
//   play_i/pause_i/stop_i  control pulses, priority stop > pause > play
//   loop_i          restart at index 0 after the last note (sampled at advance)
//   speed_i[1:0]    beat period CLK_HZ/2, /4, /8, /16 cycles
//   vol_in_i[2:0]   user volume
//   note_div_o      divider to note generator (1 = silence)
//   vol_out_o       volume to note generator
//   playing_o, paused_o, done_o, beat_tick_o, note_idx_o, count_o, full_o
//
// Optional build macro SEQ_FADE_EN: vol_out_o reloads vol_in_i at every note
// onset and steps down by one per beat inside the note (floor 1). Without it
// vol_out_o is vol_in_i delayed by one register.
// -----------------------------------------------------------------------------
module note_seq_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int GAP_CYC = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [5:0]    wr_note_i,
    input  logic [2:0]    wr_len_i,
    input  logic          clr_i,
    input  logic          play_i,
    input  logic          pause_i,
    input  logic          stop_i,
    input  logic          loop_i,
    input  logic [1:0]    speed_i,
    input  logic [2:0]    vol_in_i,
    output logic [21:0]   note_div_o,
    output logic [2:0]    vol_out_o,
    output logic          playing_o,
    output logic          paused_o,
    output logic          done_o,
    output logic          beat_tick_o,
    output logic [AW-1:0] note_idx_o,
    output logic [AW:0]   count_o,
    output logic          full_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    localparam int BW = $clog2(CLK_HZ / 2 + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    function automatic logic [21:0] scale_base(input longint base);
        longint scaled;
        scaled = (base * longint'(CLK_HZ)) / 64'sd100_000_000;
        return scaled[21:0];
    endfunction

    // Octave-3 dividers rescaled to the real clock; padded so a 4-bit index is always in range.
    localparam logic [21:0] BASE_S [16] = '{
        scale_base(64'sd764468), scale_base(64'sd721568), scale_base(64'sd681063),
        scale_base(64'sd642838), scale_base(64'sd606759), scale_base(64'sd572672),
        scale_base(64'sd540541), scale_base(64'sd510204), scale_base(64'sd481556),
        scale_base(64'sd454545), scale_base(64'sd429037), scale_base(64'sd404956),
        22'd1, 22'd1, 22'd1, 22'd1};

    function automatic logic [21:0] decode_note(input logic [5:0] code);
        logic [5:0] c;
        logic [1:0] oct;
        logic [3:0] semi;
        c = code - 6'd1;
        if (c < 6'd12) begin
            oct = 2'd0; semi = c[3:0];
        end else if (c < 6'd24) begin
            oct = 2'd1; semi = 4'(c - 6'd12);
        end else if (c < 6'd36) begin
            oct = 2'd2; semi = 4'(c - 6'd24);
        end else begin
            oct = 2'd3; semi = 4'(c - 6'd36);
        end
        if ((code == 6'd0) || (code > 6'd48)) begin
            return 22'd1;
        end else begin
            return BASE_S[semi] >> oct;
        end
    endfunction

    logic [8:0]    mem_q [DEPTH];
    logic [1:0]    state_q, state_d, resume_q, resume_d;
    logic [AW-1:0] idx_q, idx_d, nxt_idx_s;
    logic [BW-1:0] beat_q, beat_d, period_m1_s;
    logic [2:0]    left_q, left_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW:0]   count_q, count_d;
    logic [21:0]   note_div_q;
    logic [2:0]    vol_q;
    logic          playing_q, paused_q, done_q, tick_q, full_q;
    logic          tick_s, last_s, adv_s, done_s, onset_s, wr_ok_s;

    assign nxt_idx_s = idx_q + AW'(1);
    assign last_s    = ({1'b0, idx_q} + {{AW{1'b0}}, 1'b1}) >= count_q;
    assign tick_s    = (state_q == S_PLAY) && (beat_q >= period_m1_s);
    assign wr_ok_s   = (state_q == S_IDLE) && wr_en_i && !clr_i && !full_q;

    // Beat length in clock cycles minus one, selected by speed.
    always_comb begin
        case (speed_i)
            2'd0:    period_m1_s = BW'(CLK_HZ / 2 - 1);
            2'd1:    period_m1_s = BW'(CLK_HZ / 4 - 1);
            2'd2:    period_m1_s = BW'(CLK_HZ / 8 - 1);
            2'd3:    period_m1_s = BW'(CLK_HZ / 16 - 1);
            default: period_m1_s = BW'(CLK_HZ / 2 - 1);
        endcase
    end

    // Sequencer next-state: progress first, then advance, then pause override.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        idx_d    = idx_q;
        beat_d   = beat_q;
        left_d   = left_q;
        gap_d    = gap_q;
        adv_s    = 1'b0;
        done_s   = 1'b0;
        onset_s  = 1'b0;
        if (stop_i) begin
            state_d = S_IDLE;
            idx_d   = '0;
            beat_d  = '0;
            left_d  = 3'd0;
            gap_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!pause_i && play_i && (count_q != '0)) begin
                        state_d = S_PLAY;
                        idx_d   = '0;
                        beat_d  = '0;
                        left_d  = mem_q[0][2:0];
                        onset_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PLAY: begin
                    if (tick_s) begin
                        beat_d = '0;
                        if (left_q != 3'd0) begin
                            left_d = left_q - 3'd1;
                        end else if (GAP_CYC > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else begin
                            adv_s = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_q >= GW'(GAP_CYC - 1)) begin
                        adv_s = 1'b1;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                S_PAUSE: begin
                    // Counters stay frozen; a second pause is simply ignored.
                    if (!pause_i && play_i) begin
                        state_d = resume_q;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (adv_s) begin
                beat_d = '0;
                gap_d  = '0;
                if (!last_s) begin
                    state_d = S_PLAY;
                    idx_d   = nxt_idx_s;
                    left_d  = mem_q[nxt_idx_s][2:0];
                    onset_s = 1'b1;
                end else if (loop_i) begin
                    state_d = S_PLAY;
                    idx_d   = '0;
                    left_d  = mem_q[0][2:0];
                    onset_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    left_d  = 3'd0;
                    done_s  = 1'b1;
                end
            end else begin
                adv_s = 1'b0;
            end

            // The cycle in which pause arrives still counts as played time.
            if (pause_i && ((state_q == S_PLAY) || (state_q == S_GAP)) && (state_d != S_IDLE)) begin
                resume_d = state_d;
                state_d  = S_PAUSE;
            end else begin
                resume_d = resume_d;
            end
        end
    end

    // Note-memory fill level; clear wins over a simultaneous write.
    always_comb begin
        if ((state_q == S_IDLE) && clr_i) begin
            count_d = '0;
        end else if (wr_ok_s) begin
            count_d = count_q + {{AW{1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Note memory storage (no reset needed: only entries below count are read).
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[count_q[AW-1:0]] <= {wr_note_i, wr_len_i};
        end
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            resume_q   <= S_PLAY;
            idx_q      <= '0;
            beat_q     <= '0;
            left_q     <= 3'd0;
            gap_q      <= '0;
            count_q    <= '0;
            note_div_q <= 22'd1;
            playing_q  <= 1'b0;
            paused_q   <= 1'b0;
            done_q     <= 1'b0;
            tick_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            idx_q      <= idx_d;
            beat_q     <= beat_d;
            left_q     <= left_d;
            gap_q      <= gap_d;
            count_q    <= count_d;
            note_div_q <= (state_q == S_PLAY) ? decode_note(mem_q[idx_q][8:3]) : 22'd1;
            playing_q  <= (state_d == S_PLAY) || (state_d == S_GAP);
            paused_q   <= (state_d == S_PAUSE);
            done_q     <= done_s;
            tick_q     <= tick_s;
            full_q     <= (count_d == (AW+1)'(DEPTH));
        end
    end

    // Volume register: its reset value is the live input, so it loads while rst is held.
`ifdef SEQ_FADE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            vol_q <= vol_in_i;
        end else if (onset_s) begin
            vol_q <= vol_in_i;
        end else if (tick_s && (left_q != 3'd0) && (vol_q > 3'd1)) begin
            vol_q <= vol_q - 3'd1;
        end
    end
`else
    always_ff @(posedge clk) begin
        vol_q <= vol_in_i;
    end
`endif

    assign note_div_o  = note_div_q;
    assign vol_out_o   = vol_q;
    assign playing_o   = playing_q;
    assign paused_o    = paused_q;
    assign done_o      = done_q;
    assign beat_tick_o = tick_q;
    assign note_idx_o  = idx_q;
    assign count_o     = count_q;
    assign full_o      = full_q;
endmodule

// File: tb/tb_note_seq_ctrl.sv
// Directed bench for note_seq_ctrl with CLK_HZ=1600 (800-cycle beats at
// speed 0, 100-cycle beats at speed 3) and GAP_CYC=4.
// Scaled dividers: code 1 -> 764468*1600/1e8 = 12, code 13 -> 12>>1 = 6,
// code 25 -> 12>>2 = 3, code 10 (semitone 9, 454545) -> 7.
module tb_note_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst, wr_en, clr, play, pause, stop, loop_en;
    logic [5:0]  wr_note;
    logic [2:0]  wr_len, vol_in, vol_out;
    logic [1:0]  speed;
    logic [21:0] note_div;
    logic        playing, paused, done, beat_tick, full;
    logic [3:0]  note_idx;
    logic [4:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    note_seq_ctrl #(.CLK_HZ(1600), .DEPTH(16), .AW(4), .GAP_CYC(4)) dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_note_i(wr_note), .wr_len_i(wr_len),
        .clr_i(clr), .play_i(play), .pause_i(pause), .stop_i(stop), .loop_i(loop_en),
        .speed_i(speed), .vol_in_i(vol_in), .note_div_o(note_div), .vol_out_o(vol_out),
        .playing_o(playing), .paused_o(paused), .done_o(done), .beat_tick_o(beat_tick),
        .note_idx_o(note_idx), .count_o(count), .full_o(full));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_note(input logic [5:0] code, input logic [2:0] len);
        wr_en = 1'b1; wr_note = code; wr_len = len;
        step();
        wr_en = 1'b0;
    endtask

    task automatic clear_mem();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        step();
        play = 1'b0;
    endtask

    initial begin
        int n7, nbad, first7, last7, t_i1, t_i2, t_done, n_done, n_tick, wraps, prev_idx;
        int exp_vol [8];
`ifdef SEQ_FADE_EN
        exp_vol = '{5, 4, 3, 2, 1, 1, 1, 1};
`else
        exp_vol = '{5, 5, 5, 5, 5, 5, 5, 5};
`endif
        rst = 1'b1; wr_en = 1'b0; clr = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0;
        loop_en = 1'b0; wr_note = 6'd0; wr_len = 3'd0; speed = 2'd0; vol_in = 3'd5;
        repeat (3) step();

        // Reset state
        check_eq("rst_div", note_div, 1);
        check_eq("rst_play", playing, 0);
        check_eq("rst_paused", paused, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_tick", beat_tick, 0);
        check_eq("rst_idx", note_idx, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_vol", vol_out, 5);
        rst = 1'b0;
        step();

        // Three-note sequence: A3 one beat, rest two beats, invalid code one beat
        write_note(6'd10, 3'd0);
        write_note(6'd0, 3'd1);
        write_note(6'd49, 3'd0);
        check_eq("seq_count", count, 3);
        pulse_play();
        n7 = 0; nbad = 0; first7 = 0; last7 = 0; t_i1 = 0; t_i2 = 0; t_done = 0; n_done = 0; n_tick = 0;
        for (int t = 1; t <= 3300; t++) begin
            step();
            if (note_div == 22'd7) begin
                n7++;
                if (first7 == 0) first7 = t;
                last7 = t;
            end else if (note_div != 22'd1) begin
                nbad++;
            end
            if (note_idx == 4'd1 && t_i1 == 0) t_i1 = t;
            if (note_idx == 4'd2 && t_i2 == 0) t_i2 = t;
            if (done) begin
                n_done++;
                if (t_done == 0) t_done = t;
            end
            if (beat_tick) n_tick++;
            if (t == 3211) check_eq("seq_playing_gap", playing, 1);
        end
        check_eq("seq_a3_cycles", n7, 800);
        check_eq("seq_a3_first", first7, 1);
        check_eq("seq_a3_last", last7, 800);
        check_eq("seq_other_div", nbad, 0);
        check_eq("seq_idx1_at", t_i1, 804);
        check_eq("seq_idx2_at", t_i2, 2408);
        check_eq("seq_done_at", t_done, 3212);
        check_eq("seq_done_cnt", n_done, 1);
        check_eq("seq_ticks", n_tick, 4);
        check_eq("seq_end_play", playing, 0);
        check_eq("seq_end_idx", note_idx, 0);

        // Memory fill, overflow, clear, clear-beats-write, play with empty memory
        clear_mem();
        for (int i = 0; i < 16; i++) write_note(6'(i + 1), 3'd0);
        check_eq("full_count", count, 16);
        check_eq("full_flag", full, 1);
        write_note(6'd5, 3'd0);
        check_eq("full_ignored", count, 16);
        clear_mem();
        check_eq("clr_count", count, 0);
        check_eq("clr_full", full, 0);
        write_note(6'd3, 3'd0);
        check_eq("one_count", count, 1);
        clr = 1'b1; wr_en = 1'b1;
        step();
        clr = 1'b0; wr_en = 1'b0;
        check_eq("clr_wins", count, 0);
        pulse_play();
        repeat (3) step();
        check_eq("empty_play", playing, 0);
        check_eq("empty_div", note_div, 1);

        // Looping two notes at speed 3, three laps
        speed = 2'd3; loop_en = 1'b1;
        write_note(6'd1, 3'd0);
        write_note(6'd13, 3'd0);
        pulse_play();
        wraps = 0; n_done = 0; prev_idx = 0;
        for (int t = 1; t <= 700; t++) begin
            step();
            if (t == 50) check_eq("div_c1", note_div, 12);
            if (t == 154) check_eq("div_c13", note_div, 6);
            if (prev_idx == 1 && note_idx == 4'd0) wraps++;
            if (done) n_done++;
            prev_idx = int'(note_idx);
        end
        check_eq("loop_wraps", wraps, 3);
        check_eq("loop_no_done", n_done, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("loop_stop", playing, 0);
        loop_en = 1'b0;

        // Pause at beat cycle 300 for 1000 cycles, then resume
        speed = 2'd0;
        clear_mem();
        write_note(6'd10, 3'd0);
        pulse_play();
        n7 = 0; t_done = 0;
        for (int t = 1; t <= 2200; t++) begin
            step();
            if (note_div == 22'd7) n7++;
            if (done && t_done == 0) t_done = t;
            if (t == 800) begin
                check_eq("pause_div", note_div, 1);
                check_eq("pause_flag", paused, 1);
                check_eq("pause_playing", playing, 0);
            end
            pause = (t == 299);
            play  = (t == 1299);
        end
        check_eq("pause_note_cycles", n7, 800);
        check_eq("pause_done_at", t_done, 1804);

        // Simultaneous stop, pause and play while playing
        clear_mem();
        write_note(6'd10, 3'd1);
        pulse_play();
        repeat (100) step();
        stop = 1'b1; pause = 1'b1; play = 1'b1;
        step();
        stop = 1'b0; pause = 1'b0; play = 1'b0;
        check_eq("sim_playing", playing, 0);
        check_eq("sim_paused", paused, 0);
        check_eq("sim_idx", note_idx, 0);
        step();
        check_eq("sim_div", note_div, 1);
        check_eq("sim_no_done", done, 0);

        // Reset in the middle of a note
        pulse_play();
        repeat (50) step();
        check_eq("mid_div", note_div, 7);
        rst = 1'b1;
        step();
        check_eq("mrst_div", note_div, 1);
        check_eq("mrst_playing", playing, 0);
        check_eq("mrst_idx", note_idx, 0);
        check_eq("mrst_count", count, 0);
        check_eq("mrst_tick", beat_tick, 0);
        check_eq("mrst_vol", vol_out, 5);
        rst = 1'b0;
        step();

        // Volume over an eight-beat note and onset of the next note
        speed = 2'd3;
        write_note(6'd25, 3'd7);
        write_note(6'd10, 3'd0);
        pulse_play();
        t_done = 0;
        for (int t = 1; t <= 920; t++) begin
            step();
            if ((t % 100) == 50 && t < 800) check_eq("vol_beat", vol_out, exp_vol[t / 100]);
            if (t == 50) check_eq("div_c25", note_div, 3);
            if (t == 850) begin
                check_eq("vol_next_note", vol_out, 5);
                check_eq("next_div", note_div, 7);
                check_eq("next_idx", note_idx, 1);
            end
            if (done && t_done == 0) t_done = t;
        end
        check_eq("fade_done_at", t_done, 908);
`ifndef SEQ_FADE_EN
        vol_in = 3'd2;
        step();
        check_eq("vol_follow", vol_out, 2);
        vol_in = 3'd5;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
